// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor that handles CHUNK bits per clock, LSB chunk first,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   // state | meaning
   // IDLE  | waiting for operands, in_ready high
   // RUN   | one chunk added per edge, cnt selects the chunk
   // DONE  | result held until out_ready

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("serial_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] s_next;
   logic             msb_cin;
   logic             accept;

   assign in_ready  = (state == IDLE) & ~rst;
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;

   // Operands shift right each RUN edge, so the active chunk always sits at bit 0.
   always_comb begin
      chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
      msb_cin   = chunk_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
      s_next    = (S >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (cnt_q == LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         S       <= '0;
         Cout    <= 1'b0;
         Ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q     <= in1;
                  b_q     <= sub ? ~in2 : in2;
                  carry_q <= cin ^ sub;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               a_q     <= a_q >> CHUNK;
               b_q     <= b_q >> CHUNK;
               carry_q <= chunk_sum[CHUNK];
               cnt_q   <= cnt_q + 1'b1;
               S       <= s_next;
               if (cnt_q == LAST) begin
                  Cout <= chunk_sum[CHUNK];
                  Ovf  <= msb_cin ^ chunk_sum[CHUNK];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: vector table on an 8/2 instance, handshake,
// reset and throughput sequences, plus 16/4 and 8/8 instances against a small model.
module tb_serial_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       iv_a, ir_a, ov_a, or_a, sub_a, cin_a, co_a, of_a;
   logic [7:0] x_a, y_a, s_a;
   logic        iv_b, ir_b, ov_b, or_b, sub_b, cin_b, co_b, of_b;
   logic [15:0] x_b, y_b, s_b;
   logic       iv_c, ir_c, ov_c, or_c, sub_c, cin_c, co_c, of_c;
   logic [7:0] x_c, y_c, s_c;

   serial_addsub #(.WIDTH(8), .CHUNK(2)) dut_a (
      .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in1(x_a), .in2(y_a),
      .sub(sub_a), .cin(cin_a), .out_valid(ov_a), .out_ready(or_a), .S(s_a), .Cout(co_a), .Ovf(of_a));
   serial_addsub #(.WIDTH(16), .CHUNK(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in1(x_b), .in2(y_b),
      .sub(sub_b), .cin(cin_b), .out_valid(ov_b), .out_ready(or_b), .S(s_b), .Cout(co_b), .Ovf(of_b));
   serial_addsub #(.WIDTH(8), .CHUNK(8)) dut_c (
      .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .in1(x_c), .in2(y_c),
      .sub(sub_c), .cin(cin_c), .out_valid(ov_c), .out_ready(or_c), .S(s_c), .Cout(co_c), .Ovf(of_c));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: full-width add of A, B' and carry; returns {ovf, cout, s}.
   function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic sb, input logic ci);
      logic [15:0] mask, bb, aa;
      logic [16:0] full;
      logic        co, ovf;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      aa   = a & mask;
      bb   = (sb ? ~b : b) & mask;
      full = {1'b0, aa} + {1'b0, bb} + {16'h0, ci ^ sb};
      co   = full[w];
      ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
      return {ovf, co, full[15:0] & mask};
   endfunction

   task automatic set_in(input int inst, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic sb, input logic ci);
      case (inst)
         0: begin iv_a = v; x_a = a[7:0]; y_a = b[7:0]; sub_a = sb; cin_a = ci; end
         1: begin iv_b = v; x_b = a;      y_b = b;      sub_b = sb; cin_b = ci; end
         default: begin iv_c = v; x_c = a[7:0]; y_c = b[7:0]; sub_c = sb; cin_c = ci; end
      endcase
   endtask

   task automatic set_ordy(input int inst, input logic v);
      case (inst)
         0: or_a = v;
         1: or_b = v;
         default: or_c = v;
      endcase
   endtask

   function automatic logic get_ov(input int inst);
      case (inst)
         0: return ov_a;
         1: return ov_b;
         default: return ov_c;
      endcase
   endfunction

   function automatic logic get_ir(input int inst);
      case (inst)
         0: return ir_a;
         1: return ir_b;
         default: return ir_c;
      endcase
   endfunction

   function automatic logic [17:0] get_res(input int inst);
      case (inst)
         0: return {of_a, co_a, 8'h00, s_a};
         1: return {of_b, co_b, s_b};
         default: return {of_c, co_c, 8'h00, s_c};
      endcase
   endfunction

   // One full transaction; lat counts edges from the accepting edge to out_valid.
   task automatic do_op(input int inst, input logic [15:0] a, input logic [15:0] b, input logic sb,
                        input logic ci, output logic [17:0] res, output int lat);
      @(negedge clk);
      set_in(inst, 1'b1, a, b, sb, ci);
      set_ordy(inst, 1'b0);
      chk("ready_before_accept", {31'h0, get_ir(inst)}, 32'h1);
      @(posedge clk); #1;
      set_in(inst, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      lat = 0;
      while (!get_ov(inst) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid_timeout", {31'h0, get_ov(inst)}, 32'h1);
      res = get_res(inst);
      set_ordy(inst, 1'b1);
      @(posedge clk); #1;
      set_ordy(inst, 1'b0);
      chk("idle_after_release", {30'h0, get_ir(inst), get_ov(inst)}, 32'h2);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sb;
      logic       ci;
      logic [7:0] s;
      logic       co;
      logic       of;
   } vec_t;

   vec_t vt[9];

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      logic [17:0] res, exp;
      int          lat;
      int          acc_edges[$];
      logic        acc, saw_ov;
      logic [15:0] ra, rb;
      logic        rs, rc;
      int          lat_exp[3];

      lat_exp[0] = 4; lat_exp[1] = 4; lat_exp[2] = 1;

      vt[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vt[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0};
      vt[3] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
      vt[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
      vt[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
      vt[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vt[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      vt[8] = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_in(i, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
         set_ordy(i, 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", {31'h0, ir_a}, 32'h0);
      chk("reset_outputs_a", {21'h0, ov_a, of_a, co_a, s_a}, 32'h0);
      chk("reset_outputs_b", {13'h0, ov_b, of_b, co_b, s_b}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", {29'h0, ir_a, ir_b, ir_c}, 32'h7);

      for (int i = 0; i < 9; i++) begin
         do_op(0, {8'h00, vt[i].a}, {8'h00, vt[i].b}, vt[i].sb, vt[i].ci, res, lat);
         chk($sformatf("vec%0d_S", i), {24'h0, res[7:0]}, {24'h0, vt[i].s});
         chk($sformatf("vec%0d_Cout", i), {31'h0, res[16]}, {31'h0, vt[i].co});
         chk($sformatf("vec%0d_Ovf", i), {31'h0, res[17]}, {31'h0, vt[i].of});
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      end

      // Result held while out_ready is low; new operands on in_valid must be ignored.
      @(negedge clk);
      set_in(0, 1'b1, 16'h0033, 16'h0044, 1'b0, 1'b0);
      @(posedge clk); #1;
      set_in(0, 1'b1, 16'h00AA, 16'h0055, 1'b1, 1'b1);
      lat = 0;
      while (!ov_a && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hold_latency", 32'(lat), 32'd4);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d_state", k), {21'h0, ov_a, ir_a, of_a, co_a, s_a}, {21'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77});
      end
      or_a = 1'b1;
      @(posedge clk); #1;
      chk("release_idle", {30'h0, ir_a, ov_a}, 32'h2);

      // Streaming with in_valid and out_ready held high: IDLE + N RUN + DONE per op.
      // AA - 55 - 1 = AA + AA = 154 -> S=54, Cout=1, Ovf=1.
      for (int e = 0; e < 30; e++) begin
         @(negedge clk);
         acc = iv_a & ir_a;
         if (ov_a) chk("stream_result", {22'h0, of_a, co_a, s_a}, {22'h0, 1'b1, 1'b1, 8'h54});
         @(posedge clk);
         if (acc) acc_edges.push_back(e);
      end
      chk("stream_accept_count", 32'(acc_edges.size()), 32'd5);
      for (int i = 1; i < acc_edges.size(); i++)
         chk($sformatf("stream_spacing%0d", i), 32'(acc_edges[i] - acc_edges[i-1]), 32'd6);
      @(negedge clk);
      set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      repeat (8) @(posedge clk);
      @(negedge clk);
      or_a = 1'b0;
      chk("stream_drained", {30'h0, ir_a, ov_a}, 32'h2);

      // Reset after two RUN edges aborts the op.
      @(negedge clk);
      set_in(0, 1'b1, 16'h0012, 16'h0034, 1'b0, 1'b0);
      @(posedge clk); #1;
      set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_ready_in_reset", {31'h0, ir_a}, 32'h0);
      @(posedge clk); #1;
      chk("abort_outputs", {21'h0, ov_a, of_a, co_a, s_a}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready_after", {31'h0, ir_a}, 32'h1);
      saw_ov = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         saw_ov = saw_ov | ov_a;
      end
      chk("abort_no_result", {31'h0, saw_ov}, 32'h0);
      do_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, res, lat);
      chk("after_abort_S", {14'h0, res}, {14'h0, 2'b00, 16'h0002});

      do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, res, lat);
      chk("w16_wrap", {14'h0, res}, {14'h0, 2'b01, 16'h0000});
      chk("w16_latency", 32'(lat), 32'd4);
      do_op(2, 16'h0040, 16'h0040, 1'b0, 1'b0, res, lat);
      chk("w8c8_ovf", {14'h0, res}, {14'h0, 2'b10, 16'h0080});
      chk("w8c8_latency", 32'(lat), 32'd1);

      for (int n = 0; n < 1200; n++) begin
         int inst;
         inst = (n < 1000) ? 0 : ((n < 1100) ? 1 : 2);
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         exp = model((inst == 1) ? 16 : 8, ra, rb, rs, rc);
         do_op(inst, ra, rb, rs, rc, res, lat);
         chk($sformatf("rand%0d_i%0d", n, inst), {14'h0, res}, {14'h0, exp});
         chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(lat_exp[inst]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
